game_flow_ctrl: RTL and testbench

Frame-rate game sequencer for the mini-golf datapath. It debounces the centre button and issues launch and level-load commands to the ball-physics logic. It also counts strokes, tracks the current map level, and drives the victory, fail and aim overlays selected by the pixel colour mux. It sits between the button and collision inputs and the ball-movement/render logic, all in the `pixel_clk` domain.

---
 rtl/game_flow_if.sv | 30 +++
 rtl/game_flow_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_game_flow_ctrl.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/game_flow_if.sv
// Game flow bus: frame strobe, button and ball status in; commands and overlays out.
// master drives the frame/button/ball inputs, slave is the sequencer that answers them.
interface game_flow_if #(
    parameter int LW = 1
);
    logic          end_of_frame;
    logic          button_c;
    logic          ball_idle;
    logic          ball_in_hole;
    logic          launch;
    logic          load_level;
    logic [LW-1:0] level;
    logic [3:0]    shot_count;
    logic          show_aim;
    logic          show_victory;
    logic          show_fail;
    logic [2:0]    state_dbg;

    modport master (
        output end_of_frame, button_c, ball_idle, ball_in_hole,
        input  launch, load_level, level, shot_count,
        input  show_aim, show_victory, show_fail, state_dbg
    );

    modport slave (
        input  end_of_frame, button_c, ball_idle, ball_in_hole,
        output launch, load_level, level, shot_count,
        output show_aim, show_victory, show_fail, state_dbg
    );
endinterface

// File: rtl/game_flow_ctrl.sv
// Mini-golf game sequencer: debounced launch button, stroke/level tracking, overlays.
// Ports: pixel_clk, rst_n (async low), gf (game_flow_if.slave) carrying all game signals.
module game_flow_ctrl #(
    parameter int NUM_LEVELS      = 2,
    parameter int MAX_SHOTS       = 10,
    parameter int BANNER_FRAMES   = 180,
    parameter int DEBOUNCE_FRAMES = 3,
    parameter int ROLL_GUARD      = 2
) (
    input  logic pixel_clk,
    input  logic rst_n,
    game_flow_if.slave gf
);
    localparam int LW = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;
    localparam int GW = (ROLL_GUARD > 0) ? $clog2(ROLL_GUARD + 1) : 1;

    localparam logic [2:0]    DB_MAX      = 3'(DEBOUNCE_FRAMES);
    localparam logic [2:0]    DB_PRE      = 3'(DEBOUNCE_FRAMES - 1);
    localparam logic [GW-1:0] GUARD_MAX   = GW'(ROLL_GUARD);
    localparam logic [7:0]    BANNER_LAST = 8'(BANNER_FRAMES - 1);
    localparam logic [LW-1:0] LAST_LVL    = LW'(NUM_LEVELS - 1);
    localparam logic [3:0]    MAX_SH      = 4'(MAX_SHOTS);

    typedef enum logic [2:0] {
        S_LOAD = 3'd0,
        S_AIM  = 3'd1,
        S_ROLL = 3'd2,
        S_WIN  = 3'd3,
        S_FAIL = 3'd4,
        S_DONE = 3'd5
    } state_t;

    typedef struct packed {
        logic aim;
        logic vic;
        logic fail;
    } ovl_t;

    function automatic ovl_t ovl_of(state_t s);
        ovl_t o;
        o.aim  = (s == S_AIM);
        o.vic  = (s == S_WIN) || (s == S_DONE);
        o.fail = (s == S_FAIL);
        return o;
    endfunction

    logic [1:0]    btn_sync;
    logic [2:0]    db_cnt;
    logic          press;
    state_t        state;
    ovl_t          ovl;
    logic          launch_q;
    logic          load_q;
    logic [LW-1:0] level_q;
    logic [3:0]    shot_q;
    logic [GW-1:0] guard;
    logic [7:0]    banner;

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_sync <= '0;
        end else begin
            btn_sync <= {btn_sync[0], gf.button_c};
        end
    end

    // Counter saturates at the threshold, so a held button can only
    // cross DB_PRE -> DB_MAX once; a release is needed to re-arm.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt <= '0;
        end else if (gf.end_of_frame) begin
            if (!btn_sync[1]) begin
                db_cnt <= '0;
            end else if (db_cnt != DB_MAX) begin
                db_cnt <= db_cnt + 3'd1;
            end
        end
    end

    assign press = gf.end_of_frame && btn_sync[1] && (db_cnt == DB_PRE);

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_LOAD;
            ovl      <= '0;
            launch_q <= 1'b0;
            load_q   <= 1'b0;
            level_q  <= '0;
            shot_q   <= '0;
            guard    <= '0;
            banner   <= '0;
        end else begin
            launch_q <= 1'b0;
            load_q   <= 1'b0;
            if (gf.end_of_frame) begin
                case (state)
                    S_LOAD: begin
                        shot_q <= '0;
                        load_q <= 1'b1;
                        state  <= S_AIM;
                        ovl    <= ovl_of(S_AIM);
                    end
                    S_AIM: begin
                        if (press) begin
                            launch_q <= 1'b1;
                            if (shot_q != 4'hf) begin
                                shot_q <= shot_q + 4'd1;
                            end
                            guard <= '0;
                            state <= S_ROLL;
                            ovl   <= ovl_of(S_ROLL);
                        end
                    end
                    S_ROLL: begin
                        // Hole wins even inside the guard window.
                        if (gf.ball_in_hole) begin
                            banner <= '0;
                            state  <= S_WIN;
                            ovl    <= ovl_of(S_WIN);
                        end else if (guard == GUARD_MAX && gf.ball_idle) begin
                            if (shot_q == MAX_SH) begin
                                banner <= '0;
                                state  <= S_FAIL;
                                ovl    <= ovl_of(S_FAIL);
                            end else begin
                                state <= S_AIM;
                                ovl   <= ovl_of(S_AIM);
                            end
                        end else if (guard != GUARD_MAX) begin
                            guard <= guard + GW'(1);
                        end
                    end
                    S_WIN: begin
                        if (banner >= BANNER_LAST) begin
                            if (level_q == LAST_LVL) begin
                                state <= S_DONE;
                                ovl   <= ovl_of(S_DONE);
                            end else begin
                                level_q <= level_q + LW'(1);
                                state   <= S_LOAD;
                                ovl     <= ovl_of(S_LOAD);
                            end
                        end else begin
                            banner <= banner + 8'd1;
                        end
                    end
                    S_FAIL: begin
                        if (banner >= BANNER_LAST) begin
                            state <= S_LOAD;
                            ovl   <= ovl_of(S_LOAD);
                        end else begin
                            banner <= banner + 8'd1;
                        end
                    end
                    S_DONE: begin
                        if (press) begin
                            level_q <= '0;
                            state   <= S_LOAD;
                            ovl     <= ovl_of(S_LOAD);
                        end
                    end
                    default: begin
                        state <= S_LOAD;
                        ovl   <= ovl_of(S_LOAD);
                    end
                endcase
            end
        end
    end

    assign gf.launch       = launch_q;
    assign gf.load_level   = load_q;
    assign gf.level        = level_q;
    assign gf.shot_count   = shot_q;
    assign gf.show_aim     = ovl.aim;
    assign gf.show_victory = ovl.vic;
    assign gf.show_fail    = ovl.fail;
    assign gf.state_dbg    = state;
endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: directed game scenarios plus random frames.
// Frame-level reference model predicts output events; a monitor compares them.
module tb_game_flow_ctrl;
    localparam int NL = 2;
    localparam int MS = 10;
    localparam int BF = 180;
    localparam int DB = 3;
    localparam int RG = 2;

    localparam int LOAD = 0;
    localparam int AIM  = 1;
    localparam int ROLL = 2;
    localparam int WIN  = 3;
    localparam int FAIL = 4;
    localparam int DONE = 5;

    logic pixel_clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 pixel_clk = ~pixel_clk;

    game_flow_if #(.LW(1)) gf ();

    game_flow_ctrl #(
        .NUM_LEVELS(NL), .MAX_SHOTS(MS), .BANNER_FRAMES(BF),
        .DEBOUNCE_FRAMES(DB), .ROLL_GUARD(RG)
    ) dut (
        .pixel_clk(pixel_clk),
        .rst_n(rst_n),
        .gf(gf)
    );

    typedef struct {
        int st;
        int lvl;
        int shots;
        bit launch;
        bit load;
    } ev_t;

    ev_t q[$];
    int checks = 0;
    int failures = 0;

    int m_st, m_lvl, m_shots, m_guard, m_banner, m_run;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void push(bit l, bit ld);
        ev_t e;
        e.st = m_st;
        e.lvl = m_lvl;
        e.shots = m_shots;
        e.launch = l;
        e.load = ld;
        q.push_back(e);
    endfunction

    function automatic void model_reset();
        m_st = LOAD;
        m_lvl = 0;
        m_shots = 0;
        m_guard = 0;
        m_banner = 0;
        m_run = 0;
    endfunction

    // One frame of game rules, applied at the frame strobe.
    function automatic void model_step(bit b, bit idle, bit hole);
        bit press;
        m_run = b ? m_run + 1 : 0;
        press = (m_run == DB);
        case (m_st)
            LOAD: begin
                m_shots = 0;
                m_st = AIM;
                push(0, 1);
            end
            AIM: if (press) begin
                m_shots = (m_shots < 15) ? m_shots + 1 : 15;
                m_guard = 0;
                m_st = ROLL;
                push(1, 0);
            end
            ROLL: begin
                if (hole) begin
                    m_banner = 0;
                    m_st = WIN;
                    push(0, 0);
                end else if (m_guard >= RG && idle) begin
                    m_banner = 0;
                    m_st = (m_shots == MS) ? FAIL : AIM;
                    push(0, 0);
                end else begin
                    m_guard++;
                end
            end
            WIN: begin
                m_banner++;
                if (m_banner >= BF) begin
                    if (m_lvl == NL - 1) begin
                        m_st = DONE;
                    end else begin
                        m_lvl = (m_lvl + 1) % NL;
                        m_st = LOAD;
                    end
                    push(0, 0);
                end
            end
            FAIL: begin
                m_banner++;
                if (m_banner >= BF) begin
                    m_st = LOAD;
                    push(0, 0);
                end
            end
            DONE: if (press) begin
                m_lvl = 0;
                m_st = LOAD;
                push(0, 0);
            end
            default: ;
        endcase
    endfunction

    // Monitor: every pulse or state change must match the next predicted event.
    int prev_dbg = 0;
    ev_t ev;
    always @(negedge pixel_clk) begin
        if (!rst_n) begin
            prev_dbg = 0;
        end else if (gf.launch || gf.load_level ||
                     int'(gf.state_dbg) != prev_dbg) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event: got state=%0d launch=%0d load=%0d, required no event",
                         gf.state_dbg, gf.launch, gf.load_level);
            end else begin
                ev = q.pop_front();
                chk("state_dbg", int'(gf.state_dbg), ev.st);
                chk("launch", int'(gf.launch), int'(ev.launch));
                chk("load_level", int'(gf.load_level), int'(ev.load));
                chk("level", int'(gf.level), ev.lvl);
                chk("shot_count", int'(gf.shot_count), ev.shots);
                chk("show_aim", int'(gf.show_aim), int'(ev.st == AIM));
                chk("show_victory", int'(gf.show_victory),
                    int'(ev.st == WIN || ev.st == DONE));
                chk("show_fail", int'(gf.show_fail), int'(ev.st == FAIL));
            end
            prev_dbg = int'(gf.state_dbg);
        end
    end

    task automatic frame(bit b, bit idle, bit hole);
        gf.button_c = b;
        gf.ball_idle = idle;
        gf.ball_in_hole = hole;
        repeat (7) @(posedge pixel_clk);
        #1;
        gf.end_of_frame = 1'b1;
        model_step(b, idle, hole);
        @(posedge pixel_clk);
        #1;
        gf.end_of_frame = 1'b0;
    endtask

    task automatic launch_shot();
        frame(0, 0, 0);
        repeat (DB) frame(1, 0, 0);
    endtask

    task automatic check_all_zero(string tag);
        chk({tag, "_launch"}, int'(gf.launch), 0);
        chk({tag, "_load"}, int'(gf.load_level), 0);
        chk({tag, "_level"}, int'(gf.level), 0);
        chk({tag, "_shots"}, int'(gf.shot_count), 0);
        chk({tag, "_aim"}, int'(gf.show_aim), 0);
        chk({tag, "_vic"}, int'(gf.show_victory), 0);
        chk({tag, "_fail"}, int'(gf.show_fail), 0);
        chk({tag, "_state"}, int'(gf.state_dbg), 0);
    endtask

    initial begin
        gf.end_of_frame = 1'b0;
        gf.button_c = 1'b0;
        gf.ball_idle = 1'b0;
        gf.ball_in_hole = 1'b0;
        model_reset();
        repeat (3) @(posedge pixel_clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        // Load, then glitch that must not launch, then a real press held long.
        repeat (2) frame(0, 0, 0);
        repeat (2) frame(1, 0, 0);
        frame(0, 0, 0);
        repeat (3) frame(1, 0, 0);
        repeat (20) frame(1, 0, 0);
        frame(0, 1, 0);

        // Idle during the guard window is ignored.
        launch_shot();
        repeat (3) frame(0, 1, 0);

        // Hole beats idle on level 0, banner, then level 1.
        launch_shot();
        frame(0, 1, 1);
        repeat (BF) frame(0, 0, 0);
        frame(0, 0, 0);

        // Run out of strokes on level 1.
        repeat (MS) begin
            launch_shot();
            repeat (3) frame(0, 1, 0);
        end
        repeat (BF) frame(0, 0, 0);
        frame(0, 0, 0);

        // Win the last level, sit in DONE, restart with a press.
        launch_shot();
        frame(0, 0, 1);
        repeat (BF) frame(0, 0, 0);
        repeat (4) frame(0, 0, 0);
        repeat (DB) frame(1, 0, 0);
        frame(0, 0, 0);

        // Reach a WIN on level 1 and reset in the middle of the banner.
        launch_shot();
        frame(0, 0, 1);
        repeat (BF) frame(0, 0, 0);
        frame(0, 0, 0);
        launch_shot();
        frame(0, 0, 1);
        repeat (50) frame(0, 0, 0);
        chk("mid_win_victory", int'(gf.show_victory), 1);
        chk("mid_win_level", int'(gf.level), 1);
        @(posedge pixel_clk);
        #2;
        rst_n = 1'b0;
        gf.button_c = 1'b0;
        #1;
        check_all_zero("midwin_rst");
        q.delete();
        model_reset();
        repeat (3) @(posedge pixel_clk);
        #1;
        rst_n = 1'b1;

        // Random play.
        for (int i = 0; i < 700; i++) begin
            frame($urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 24) == 0);
        end
        frame(0, 0, 0);
        repeat (4) @(posedge pixel_clk);

        chk("pending_events", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
